// File: rtl/responder_pkg.sv
// Shared types and helpers for the quiz-responder controller: FSM states,
// BCD digit type and the button priority encoder.
package responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WIN     = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam int PLAYER_ID_W     = 4;
    localparam int NUM_PLAYERS_MAX = 9;

    typedef logic [PLAYER_ID_W-1:0] player_id_t;

    // Lowest set bit wins; bit i maps to player ID i+1, 0 when nothing is set.
    function automatic player_id_t prio_encode(input logic [NUM_PLAYERS_MAX-1:0] req);
        player_id_t id;
        id = '0;
        for (int i = NUM_PLAYERS_MAX - 1; i >= 0; i--) begin
            if (req[i]) id = player_id_t'(i + 1);
        end
        return id;
    endfunction

endpackage

// File: rtl/responder_ctrl_if.sv
// Host/player/display signal bundle of the responder controller; the master
// side drives buttons and host controls, the slave side drives the display.
interface responder_ctrl_if #(parameter int NUM_PLAYERS = 8);

    logic                       Start;
    logic                       Clear;
    logic [NUM_PLAYERS-1:0]     Key_In;
    responder_pkg::player_id_t  Player_Number;
    responder_pkg::bcd_t        TimerH;
    responder_pkg::bcd_t        TimerL;
    logic                       Winner_Valid;
    logic                       Timeout;
    logic                       Running;
    logic                       Buzzer_Out;

    modport master (
        output Start, Clear, Key_In,
        input  Player_Number, TimerH, TimerL, Winner_Valid, Timeout, Running, Buzzer_Out
    );

    modport slave (
        input  Start, Clear, Key_In,
        output Player_Number, TimerH, TimerL, Winner_Valid, Timeout, Running, Buzzer_Out
    );

endinterface

// File: rtl/bcd_countdown.sv
// Seconds prescaler plus a two-digit BCD down-counter. Load wins over counting;
// freeze suspends both prescaler and digits for the current cycle.
module bcd_countdown
    import responder_pkg::*;
#(
    parameter int   TICK_DIV = 50000000,
    parameter bcd_t START_H  = 4'd3,
    parameter bcd_t START_L  = 4'd0
) (
    input  logic CLK,
    input  logic RST,
    input  logic load_i,
    input  logic enable_i,
    input  logic freeze_i,
    output bcd_t tens_o,
    output bcd_t units_o,
    output logic expire_o,
    output logic zero_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    bcd_t          tens_q, tens_d;
    bcd_t          units_q, units_d;
    logic          tick;

    assign tick     = enable_i && !freeze_i && (presc_q == PRESC_LAST);
    assign expire_o = tick && (tens_q == 4'd0) && (units_q == 4'd1);
    assign zero_o   = (tens_q == 4'd0) && (units_q == 4'd0);
    assign tens_o   = tens_q;
    assign units_o  = units_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        presc_d = presc_q;
        tens_d  = tens_q;
        units_d = units_q;
        if (load_i) begin
            presc_d = '0;
            tens_d  = START_H;
            units_d = START_L;
        end else if (enable_i && !freeze_i) begin
            if (tick) begin
                presc_d = '0;
                if (units_q == 4'd0) begin
                    units_d = 4'd9;
                    tens_d  = tens_q - 4'd1;
                end else begin
                    units_d = units_q - 4'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q <= '0;
            tens_q  <= START_H;
            units_q <= START_L;
        end else begin
            presc_q <= presc_d;
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/responder_ctrl.sv
// Quiz-responder controller: arms a round on Start, arbitrates the first
// button press against a BCD countdown, then latches the winner and buzzes.
module responder_ctrl
    import responder_pkg::*;
#(
    parameter int   NUM_PLAYERS = 8,
    parameter int   TICK_DIV    = 50000000,
    parameter bcd_t START_H     = 4'd3,
    parameter bcd_t START_L     = 4'd0,
    parameter int   BUZZ_CYCLES = 25000000
) (
    input  logic                   CLK,
    input  logic                   RST,
    responder_ctrl_if.slave        bus
);

    localparam int BW = $clog2(BUZZ_CYCLES + 1);

    state_e                 state_q, state_d;
    player_id_t             player_q, player_d;
    logic                   buzz_on_q, buzz_on_d;
    logic [BW-1:0]          buzz_cnt_q, buzz_cnt_d;
    logic                   start_prev_q;
    logic [NUM_PLAYERS-1:0] key_prev_q;

    logic                   start_edge;
    logic [NUM_PLAYERS-1:0] key_edge;
    logic                   any_press;
    logic                   arm_buzzer;
    logic                   timer_expire;
    logic                   timer_zero;

    assign start_edge = bus.Start && !start_prev_q;
    assign key_edge   = bus.Key_In & ~key_prev_q;
    assign any_press  = (state_q == ST_RUN) && (|key_edge);

    bcd_countdown #(
        .TICK_DIV (TICK_DIV),
        .START_H  (START_H),
        .START_L  (START_L)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load_i   (bus.Clear || (state_q == ST_IDLE)),
        .enable_i (state_q == ST_RUN),
        .freeze_i (any_press),
        .tens_o   (bus.TimerH),
        .units_o  (bus.TimerL),
        .expire_o (timer_expire),
        .zero_o   (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        player_d   = player_q;
        buzz_on_d  = buzz_on_q;
        buzz_cnt_d = buzz_cnt_q;
        arm_buzzer = 1'b0;

        if (buzz_on_q) begin
            if (buzz_cnt_q == '0) buzz_on_d  = 1'b0;
            else                  buzz_cnt_d = buzz_cnt_q - 1'b1;
        end

        if (bus.Clear) begin
            state_d    = ST_IDLE;
            player_d   = '0;
            buzz_on_d  = 1'b0;
            buzz_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A 00 start value is not a playable round, so it times out at once.
                    if (start_edge) begin
                        if (timer_zero) begin
                            state_d    = ST_TIMEOUT;
                            arm_buzzer = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (any_press) begin
                        state_d    = ST_WIN;
                        player_d   = prio_encode(NUM_PLAYERS_MAX'(key_edge));
                        arm_buzzer = 1'b1;
                    end else if (timer_expire) begin
                        state_d    = ST_TIMEOUT;
                        arm_buzzer = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (arm_buzzer) begin
            buzz_on_d  = 1'b1;
            buzz_cnt_d = BW'(BUZZ_CYCLES - 1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            player_q     <= '0;
            buzz_on_q    <= 1'b0;
            buzz_cnt_q   <= '0;
            start_prev_q <= 1'b0;
            key_prev_q   <= '0;
        end else begin
            state_q      <= state_d;
            player_q     <= player_d;
            buzz_on_q    <= buzz_on_d;
            buzz_cnt_q   <= buzz_cnt_d;
            start_prev_q <= bus.Start;
            key_prev_q   <= bus.Key_In;
        end
    end

    assign bus.Player_Number = player_q;
    assign bus.Winner_Valid  = (state_q == ST_WIN);
    assign bus.Timeout       = (state_q == ST_TIMEOUT);
    assign bus.Running       = (state_q == ST_RUN);
    assign bus.Buzzer_Out    = buzz_on_q;

endmodule

// File: tb/tb_responder_ctrl.sv
// Self-checking bench for responder_ctrl: vector table, directed corner cases
// and a randomized run against a seconds-based reference model.
module tb_responder_ctrl;
    import responder_pkg::*;

    localparam int   NP = 8;
    localparam int   TD = 4;
    localparam int   BZ = 3;
    localparam bcd_t SH = 4'd3;
    localparam bcd_t SL = 4'd0;
    localparam int   START_SECS = SH * 10 + SL;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_WIN  = 2;
    localparam int P_TO   = 3;

    logic CLK = 1'b0;
    logic RST;

    responder_ctrl_if #(.NUM_PLAYERS(NP)) bus();

    responder_ctrl #(
        .NUM_PLAYERS (NP),
        .TICK_DIV    (TD),
        .START_H     (SH),
        .START_L     (SL),
        .BUZZ_CYCLES (BZ)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: remaining seconds as an integer, cycles into the current second,
    // and the number of buzzer cycles still owed.
    int                m_phase, m_secs, m_tick, m_player, m_buzz;
    logic              m_prev_start;
    logic [NP-1:0]     m_prev_keys;

    task automatic model_step();
        logic          se;
        logic [NP-1:0] ke;
        if (RST) begin
            m_phase = P_IDLE; m_secs = START_SECS; m_tick = 0; m_player = 0; m_buzz = 0;
            m_prev_start = 1'b0; m_prev_keys = '0;
            return;
        end
        se = bus.Start & ~m_prev_start;
        ke = bus.Key_In & ~m_prev_keys;
        m_prev_start = bus.Start;
        m_prev_keys  = bus.Key_In;
        if (bus.Clear) begin
            m_phase = P_IDLE; m_secs = START_SECS; m_tick = 0; m_player = 0; m_buzz = 0;
        end else if (m_phase == P_IDLE) begin
            if (se) begin
                m_secs = START_SECS;
                m_tick = 0;
                if (START_SECS == 0) begin m_phase = P_TO; m_buzz = BZ; end
                else m_phase = P_RUN;
            end
        end else if (m_phase == P_RUN) begin
            if (ke != 0) begin
                m_player = 0;
                for (int i = NP - 1; i >= 0; i--) if (ke[i]) m_player = i + 1;
                m_phase = P_WIN;
                m_buzz  = BZ;
            end else begin
                m_tick++;
                if (m_tick == TD) begin
                    m_tick = 0;
                    m_secs--;
                    if (m_secs == 0) begin m_phase = P_TO; m_buzz = BZ; end
                end
            end
        end else if (m_buzz > 0) begin
            m_buzz--;
        end
    endtask

    function automatic logic [15:0] model_out();
        return {4'(m_player), 4'(m_secs / 10), 4'(m_secs % 10),
                m_phase == P_WIN, m_phase == P_TO, m_phase == P_RUN, m_buzz > 0};
    endfunction

    function automatic logic [15:0] dut_out();
        return {bus.Player_Number, bus.TimerH, bus.TimerL,
                bus.Winner_Valid, bus.Timeout, bus.Running, bus.Buzzer_Out};
    endfunction

    task automatic set_in(input logic rst, input logic start, input logic clear, input logic [NP-1:0] keys);
        RST = rst; bus.Start = start; bus.Clear = clear; bus.Key_In = keys;
    endtask

    task automatic step_only();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cycle();
        step_only();
        check("outputs", dut_out(), model_out());
    endtask

    typedef struct {
        logic          rst;
        logic          start;
        logic          clear;
        logic [NP-1:0] keys;
        logic [15:0]   exp;
    } vec_t;

    vec_t vecs[13];

    int n;
    int buzz_hi;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(1'b1, 1'b0, 1'b0, '0);

        // {player, H, L, winner, timeout, running, buzzer}
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 16'h0300};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 16'h0300};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h01, 16'h0300};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0300};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h01, 16'h0300};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h01, 16'h0302};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0302};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h01, 16'h1309};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h1309};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h1309};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h1308};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 16'h0300};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0300};

        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].rst, vecs[i].start, vecs[i].clear, vecs[i].keys);
            step_only();
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // Full countdown to timeout, then buzzer length.
        set_in(1'b0, 1'b1, 1'b0, '0);
        cycle();
        bus.Start = 1'b0;
        n = 0;
        while (!bus.Timeout && n < 200) begin
            cycle();
            n++;
            if (n == 44) check("timer_at_44", {bus.TimerH, bus.TimerL}, 8'h19);
        end
        check("timeout_latency", n, 120);
        check("timeout_timer", {bus.TimerH, bus.TimerL, bus.Running}, {8'h00, 1'b0});
        buzz_hi = bus.Buzzer_Out ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (bus.Buzzer_Out) buzz_hi++;
        end
        check("buzzer_cycles", buzz_hi, BZ);

        // Win by player 5; later presses and Start are ignored.
        set_in(1'b0, 1'b0, 1'b1, '0); cycle();
        set_in(1'b0, 1'b1, 1'b0, '0); cycle();
        bus.Start = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        bus.Key_In = 8'h10; cycle();
        check("win5", {bus.Player_Number, bus.TimerH, bus.TimerL, bus.Winner_Valid}, {4'd5, 8'h28, 1'b1});
        bus.Key_In = 8'h00; cycle();
        bus.Key_In = 8'h01; bus.Start = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        check("win5_hold", {bus.Player_Number, bus.TimerH, bus.TimerL, bus.Winner_Valid}, {4'd5, 8'h28, 1'b1});

        // Button held through Start must be released and pressed again.
        set_in(1'b0, 1'b0, 1'b1, 8'h80); cycle();
        set_in(1'b0, 1'b1, 1'b0, 8'h80); cycle();
        bus.Start = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        check("held_no_win", {bus.Player_Number, bus.Running}, {4'd0, 1'b1});
        bus.Key_In = 8'h00; cycle();
        bus.Key_In = 8'h80; cycle();
        check("repress_win", {bus.Player_Number, bus.Winner_Valid}, {4'd8, 1'b1});

        // Simultaneous press: lowest index wins.
        set_in(1'b0, 1'b0, 1'b1, 8'h00); cycle();
        set_in(1'b0, 1'b1, 1'b0, 8'h00); cycle();
        bus.Start = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        bus.Key_In = 8'h24; cycle();
        check("tie_win", {bus.Player_Number, bus.Winner_Valid}, {4'd3, 1'b1});

        // Press lands on the terminal tick: the press wins with 01 frozen.
        set_in(1'b0, 1'b0, 1'b1, 8'h00); cycle();
        set_in(1'b0, 1'b1, 1'b0, 8'h00); cycle();
        bus.Start = 1'b0;
        for (int i = 0; i < 119; i++) cycle();
        bus.Key_In = 8'h02; cycle();
        check("race_timer", {bus.TimerH, bus.TimerL}, 8'h01);
        check("race_flags", {bus.Winner_Valid, bus.Timeout}, 2'b10);
        check("race_player", bus.Player_Number, 4'd2);

        // Clear beats Start and a key edge on the same cycle.
        bus.Key_In = 8'h00; cycle();
        set_in(1'b0, 1'b1, 1'b1, 8'h02); cycle();
        check("clear_priority", dut_out(), 16'h0300);
        set_in(1'b0, 1'b0, 1'b0, 8'h00); cycle();

        // Reset in the middle of a round.
        set_in(1'b0, 1'b1, 1'b0, 8'h00); cycle();
        bus.Start = 1'b0;
        for (int i = 0; i < 9; i++) cycle();
        check("mid_run", bus.Running, 1'b1);
        RST = 1'b1; cycle();
        check("rst_mid_run", dut_out(), 16'h0300);
        RST = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            RST       = ($urandom_range(0, 299) == 0);
            bus.Clear = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 19) == 0) bus.Start = ~bus.Start;
            if ($urandom_range(0, 15) == 0) bus.Key_In = NP'($urandom & $urandom & $urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
